// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// hilo_muldiv_ctrl : HI/LO register owner with fixed-latency multiply path and
//                    radix-2 restoring divider, ready/valid to the EX stage.
// Revision: 1.0
// ============================================================================
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [12:0] req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        req_ready,
  output logic        busy,
  output logic        done,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0] c_MUL_CNT = 5'(MUL_LAT - 1);
  localparam logic [4:0] c_DIV_CNT = 5'd31;

  state_t      r_state;
  logic [31:0] r_hi, r_lo, r_a, r_b, r_res, r_quo, r_rem, r_dvs;
  logic [4:0]  r_cnt;
  logic        r_sgn, r_gpr, r_acc, r_sub;

  logic [12:0] w_sel;
  logic        w_accept, w_mulcls, w_divcls, w_sel_sgn, w_to_idle, w_ge;
  logic [31:0] w_abs_a, w_abs_b, w_quo_n, w_rem_n, w_q_fix, w_r_fix;
  logic [32:0] w_shift, w_diff;
  logic [63:0] w_pa, w_pb, w_prod, w_hilo, w_acc;

  // Isolating the lowest set bit gives "lowest index wins" for multi-hot ops.
  assign w_sel     = req_op & (~req_op + 13'd1);
  assign w_accept  = req_valid & (r_state == S_IDLE) & ~flush;
  assign w_mulcls  = |w_sel[12:6];
  assign w_divcls  = |w_sel[5:4];
  assign w_sel_sgn = w_sel[4] | w_sel[6] | w_sel[8] | w_sel[9] | w_sel[11];
  assign w_abs_a   = (w_sel[4] & src_a[31]) ? (32'd0 - src_a) : src_a;
  assign w_abs_b   = (w_sel[4] & src_b[31]) ? (32'd0 - src_b) : src_b;

  // Low 64 bits of the product of sign/zero-extended operands.
  assign w_pa   = {{32{r_sgn & r_a[31]}}, r_a};
  assign w_pb   = {{32{r_sgn & r_b[31]}}, r_b};
  assign w_prod = w_pa * w_pb;
  assign w_hilo = {r_hi, r_lo};
  assign w_acc  = r_sub ? (w_hilo - w_prod) : (w_hilo + w_prod);

  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[32];
  assign w_rem_n = w_ge ? w_diff[31:0] : w_shift[31:0];
  assign w_quo_n = {r_quo[30:0], w_ge};
  assign w_q_fix = (r_sgn & (r_a[31] ^ r_b[31])) ? (32'd0 - w_quo_n) : w_quo_n;
  assign w_r_fix = (r_sgn & r_a[31]) ? (32'd0 - w_rem_n) : w_rem_n;

  assign w_to_idle = (r_state == S_DONE) |
                     (((r_state == S_MUL) | (r_state == S_DIV)) & flush);

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE) & ~flush;
  assign hi        = r_hi;
  assign lo        = r_lo;

  always_comb begin
    res_valid = 1'b0;
    res_data  = 32'd0;
    if (w_accept && w_sel[2]) begin
      res_valid = 1'b1;
      res_data  = r_hi;
    end else if (w_accept && w_sel[3]) begin
      res_valid = 1'b1;
      res_data  = r_lo;
    end else if ((r_state == S_DONE) && r_gpr && !flush) begin
      res_valid = 1'b1;
      res_data  = r_res;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_res   <= 32'd0;
      r_quo   <= 32'd0;
      r_rem   <= 32'd0;
      r_dvs   <= 32'd0;
      r_cnt   <= 5'd0;
      r_sgn   <= 1'b0;
      r_gpr   <= 1'b0;
      r_acc   <= 1'b0;
      r_sub   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (w_sel[0]) r_hi <= src_a;
          if (w_sel[1]) r_lo <= src_a;
          if (w_mulcls || w_divcls) begin
            r_a   <= src_a;
            r_b   <= src_b;
            r_sgn <= w_sel_sgn;
            r_gpr <= w_sel[8];
            r_acc <= |w_sel[12:9];
            r_sub <= |w_sel[12:11];
          end
          if (w_mulcls) begin
            r_state <= S_MUL;
            r_cnt   <= c_MUL_CNT;
          end
          if (w_divcls) begin
            r_state <= S_DIV;
            r_cnt   <= c_DIV_CNT;
            r_quo   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_rem   <= 32'd0;
          end
        end
        S_MUL: if (!flush) begin
          if (r_cnt == 5'd0) begin
            if (r_gpr) r_res <= w_prod[31:0];
            else {r_hi, r_lo} <= r_acc ? w_acc : w_prod;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_DIV: if (!flush) begin
          r_quo <= w_quo_n;
          r_rem <= w_rem_n;
          if (r_cnt == 5'd0) begin
            if (r_b == 32'd0) begin
              r_hi <= r_a;
              r_lo <= 32'hFFFF_FFFF;
            end else begin
              r_hi <= w_r_fix;
              r_lo <= w_q_fix;
            end
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_to_idle) begin
        r_state <= S_IDLE;
        r_cnt   <= 5'd0;
        r_a     <= 32'd0;
        r_b     <= 32'd0;
        r_quo   <= 32'd0;
        r_rem   <= 32'd0;
        r_dvs   <= 32'd0;
        r_sgn   <= 1'b0;
        r_gpr   <= 1'b0;
        r_acc   <= 1'b0;
        r_sub   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
